// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and debounces raw A/B encoder channels and
// turns accepted Gray-code transitions into a one-cycle step strobe E with direction F.
module quad_step_decoder #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       en,
  input  logic       clr_err,
  output logic       E,
  output logic       F,
  output logic       err,
  output logic [1:0] ab_q
);

  localparam int unsigned    CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILL
  } step_e;

  logic [1:0]    a_sync;
  logic [1:0]    b_sync;
  logic [1:0]    ab_s;
  logic [1:0]    cand;
  logic [CW-1:0] cnt;
  logic          init;
  logic          accept;
  logic          err_set;
  step_e         step;

  // Two-flop synchroniser per channel; index 0 is the metastability stage.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sync <= 2'b00;
      b_sync <= 2'b00;
    end else begin
      a_sync <= {a_sync[0], a_in};
      b_sync <= {b_sync[0], b_in};
    end
  end

  assign ab_s = {a_sync[1], b_sync[1]};

  // A candidate is qualified once it has been seen on DB_CYCLES+1 consecutive edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand <= 2'b00;
      cnt  <= '0;
    end else if (ab_s != cand) begin
      cand <= ab_s;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign accept = (ab_s == cand) && (cnt == CNT_MAX) && ((ab_q != cand) || !init);

  // Forward Gray successor of x is {x[0], ~x[1]}; reverse successor is {~x[0], x[1]}.
  // NOTE: defaults are assigned first so no path leaves step unassigned (no latch).
  always_comb begin
    step = STEP_NONE;
    if (cand == {ab_q[0], ~ab_q[1]}) begin
      step = STEP_FWD;
    end else if (cand == {~ab_q[0], ab_q[1]}) begin
      step = STEP_REV;
    end else if (cand != ab_q) begin
      step = STEP_ILL;
    end
  end

  assign err_set = accept && init && (step == STEP_ILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      E    <= 1'b0;
      F    <= 1'b0;
      ab_q <= 2'b00;
      init <= 1'b0;
    end else begin
      E <= 1'b0;
      if (accept) begin
        ab_q <= cand;
        if (!init) begin
          init <= 1'b1;
        end else begin
          case (step)
            STEP_FWD: begin
              F <= 1'b0;
              E <= en;
            end
            STEP_REV: begin
              F <= 1'b1;
              E <= en;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // A new illegal transition on the same edge as clr_err keeps err set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (clr_err) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed vector table, hand-written corner sequences,
// and random input traffic compared every cycle against a behavioural model.
module tb_quad_step_decoder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in;
  logic       b_in;
  logic       en;
  logic       clr_err;
  logic       E;
  logic       F;
  logic       err;
  logic [1:0] ab_q;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;

  quad_step_decoder #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .en      (en),
    .clr_err (clr_err),
    .E       (E),
    .F       (F),
    .err     (err),
    .ab_q    (ab_q)
  );

  always #5 clk = ~clk;

  // Behavioural reference: raw input reaches the debouncer two edges later; a value
  // seen on DB+1 consecutive edges is accepted. Direction comes from the position
  // of each code on the Gray cycle 00,01,11,10.
  logic [1:0] pipe [2];
  logic [1:0] m_val  = 2'b00;
  int         m_run  = 1;
  logic       m_init = 1'b0;
  logic [1:0] m_ab   = 2'b00;
  logic       m_E    = 1'b0;
  logic       m_F    = 1'b0;
  logic       m_err  = 1'b0;

  function automatic int gray_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  initial begin
    pipe[0] = 2'b00;
    pipe[1] = 2'b00;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe[0] = 2'b00;
      pipe[1] = 2'b00;
      m_val   = 2'b00;
      m_run   = 1;
      m_init  = 1'b0;
      m_ab    = 2'b00;
      m_E     = 1'b0;
      m_F     = 1'b0;
      m_err   = 1'b0;
    end else begin
      logic [1:0] s;
      logic       set;
      int         delta;
      s       = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = {a_in, b_in};
      if (s == m_val) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_val = s;
        m_run = 1;
      end
      m_E = 1'b0;
      set = 1'b0;
      if (m_run >= DB + 1 && (m_val != m_ab || !m_init)) begin
        if (m_init) begin
          delta = (gray_pos(m_val) - gray_pos(m_ab) + 4) % 4;
          if (delta == 1) begin
            m_F = 1'b0;
            m_E = en;
          end else if (delta == 3) begin
            m_F = 1'b1;
            m_E = en;
          end else begin
            m_err = 1'b1;
            set   = 1'b1;
          end
        end
        m_init = 1'b1;
        m_ab   = m_val;
      end
      if (!set && clr_err) m_err = 1'b0;
    end
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: outputs are sampled on the falling edge, then inputs may change.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("model {E,F,err,ab_q}", {E, F, err, ab_q}, {m_E, m_F, m_err, m_ab});
    if (E) pulse_cnt++;
  endtask

  typedef struct {
    logic [1:0] ab;
    logic       en;
    logic       clr;
    int         hold;
    int         pulses;
    logic       f;
    logic       err;
    logic [1:0] abq;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [1:0] ab, input logic e, input logic c, input int hold,
                              input int pulses, input logic f, input logic er, input logic [1:0] abq);
    vec_t v;
    v.ab = ab; v.en = e; v.clr = c; v.hold = hold; v.pulses = pulses;
    v.f = f; v.err = er; v.abq = abq;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(2'b00, 1, 0, 10, 0, 0, 0, 2'b00);  // reset idle, init without pulse
    tbl[1]  = mk(2'b01, 1, 0, 20, 1, 0, 0, 2'b01);  // forward steps
    tbl[2]  = mk(2'b11, 1, 0, 20, 1, 0, 0, 2'b11);
    tbl[3]  = mk(2'b10, 1, 0, 20, 1, 0, 0, 2'b10);
    tbl[4]  = mk(2'b00, 1, 0, 20, 1, 0, 0, 2'b00);
    tbl[5]  = mk(2'b10, 1, 0, 20, 1, 1, 0, 2'b10);  // reverse steps
    tbl[6]  = mk(2'b11, 1, 0, 20, 1, 1, 0, 2'b11);
    tbl[7]  = mk(2'b01, 1, 0, 20, 1, 1, 0, 2'b01);
    tbl[8]  = mk(2'b00, 1, 0, 20, 1, 1, 0, 2'b00);
    tbl[9]  = mk(2'b01, 1, 0, 3,  0, 1, 0, 2'b00);  // 3-cycle glitch
    tbl[10] = mk(2'b00, 1, 0, 20, 0, 1, 0, 2'b00);
    tbl[11] = mk(2'b11, 1, 0, 20, 0, 1, 1, 2'b11);  // illegal jump
    tbl[12] = mk(2'b11, 1, 1, 1,  0, 1, 0, 2'b11);  // clr_err pulse
    tbl[13] = mk(2'b11, 1, 0, 5,  0, 1, 0, 2'b11);
    tbl[14] = mk(2'b10, 0, 0, 20, 0, 0, 0, 2'b10);  // disabled step still updates F/ab_q
    tbl[15] = mk(2'b00, 1, 0, 20, 1, 0, 0, 2'b00);  // re-enabled: next step pulses

    rst = 1'b0; a_in = 1'b0; b_in = 1'b0; en = 1'b1; clr_err = 1'b0;
    #1;
    check("reset outputs", {E, F, err, ab_q}, 5'b00000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      {a_in, b_in} = tbl[i].ab;
      en           = tbl[i].en;
      clr_err      = tbl[i].clr;
      pulse_cnt    = 0;
      for (int c = 0; c < tbl[i].hold; c++) tick();
      clr_err = 1'b0;
      check($sformatf("tbl[%0d] pulses", i), 5'(pulse_cnt), 5'(tbl[i].pulses));
      check($sformatf("tbl[%0d] {F,err,ab_q}", i), {1'b0, F, err, ab_q},
            {1'b0, tbl[i].f, tbl[i].err, tbl[i].abq});
    end

    // Latency: change before edge k, E high after edge k+6 and only for that cycle.
    {a_in, b_in} = 2'b01;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("latency E tick %0d", c), {4'b0, E}, {4'b0, c == 7});
    end
    check("latency F/ab_q", {2'b0, F, ab_q}, {2'b0, 1'b0, 2'b01});
    for (int c = 0; c < 10; c++) tick();

    // clr_err asserted on the very edge that flags an illegal jump: set wins.
    {a_in, b_in} = 2'b10;
    for (int c = 0; c < 6; c++) tick();
    check("err before set edge", {4'b0, err}, 5'b00000);
    clr_err = 1'b1;
    tick();
    check("set beats clr", {E, 1'b0, err, ab_q}, {1'b0, 1'b0, 1'b1, 2'b10});
    tick();
    clr_err = 1'b0;
    check("clr after set", {4'b0, err}, 5'b00000);

    // Asynchronous reset in the middle of debouncing a new value.
    {a_in, b_in} = 2'b11;
    for (int c = 0; c < 3; c++) tick();
    #2 rst = 1'b0;
    #1;
    check("async reset immediate", {E, F, err, ab_q}, 5'b00000);
    @(negedge clk);
    rst = 1'b1;
    pulse_cnt = 0;
    for (int c = 0; c < 10; c++) tick();
    check("reinit pulses", 5'(pulse_cnt), 5'd0);
    check("reinit state", {E, F, err, ab_q}, {1'b0, 1'b0, 1'b0, 2'b11});

    // Random traffic: arbitrary codes (including illegal jumps) with random hold times.
    for (int n = 0; n < 400; n++) begin
      int hold;
      {a_in, b_in} = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        clr_err = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    clr_err = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
